exmem_wb_skid_stage: RTL and testbench
======================================

// Module: exmem_wb_skid_stage
// PURPOSE
//  EX/MEM -> WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Upstream can stall on a registered in_ready, with no combinational ready path.
//  Supports flush with drop accounting and has saturating stall/drop counters.
//  Sits between the EXMEM stage and register-file writeback; payload widths are parametrised.
// PARAMETERS
//  DATA_W   64  width of ALU result and memory read data
//  RADDR_W  5   destination register index width
//  PPP_W    3   partition/participation field width
//  CNT_W    16  width of stall_cnt and drop_cnt (saturating)
// PORTS
//  clk              in   1        clock
//  reset            in   1        synchronous, active-high reset
//  flush            in   1        synchronous squash of all held entries
//  in_valid         in   1        upstream entry valid
//  in_ready         out  1        stage can accept; registered, = (state != FULL)
//  in_wr_en         in   1        regfile write enable
//  in_rd            in   RADDR_W  destination register
//  in_rd_sel        in   1        0: ALU result, 1: memory data
//  in_alu           in   DATA_W   ALU result
//  in_mem           in   DATA_W   memory read data
//  in_ppp           in   PPP_W    partition field
//  out_valid        out  1        WB entry valid
//  out_ready        in   1        WB consumes the entry this cycle
//  out_wr_en        out  1        registered wr_en AND out_valid; never 1 when invalid
//  out_rd/out_rd_sel/out_alu/out_mem/out_ppp  out  as inputs  registered payload
//  stall_cnt        out  CNT_W    cycles with out_valid & !out_ready
//  drop_cnt         out  CNT_W    valid entries discarded by flush
// BEHAVIOUR
//  - Reset (priority 1): state=EMPTY, all payload regs=0, out_valid=0, out_wr_en=0,
//    counters=0. in_ready=1 in the first cycle after reset.
//  - Flush (priority 2, reset low): state->EMPTY, out and skid payloads cleared to 0,
//    out_valid=0. A same-cycle input handshake is discarded and not counted.
//    drop_cnt += number of valid entries held: EMPTY 0, BUSY 1, FULL 2 (saturating).
//    stall_cnt is unaffected.
//  - Accept = in_valid & in_ready; release = out_valid & out_ready.
//  - FSM (out reg = R, skid reg = S):
//    EMPTY: accept -> R<=in, BUSY.
//    BUSY:  accept&release -> R<=in, stay BUSY.
//           accept&!release -> S<=in, FULL.
//           !accept&release -> EMPTY.
//           otherwise hold.
//    FULL:  release -> R<=S, BUSY. in_ready=0, so no input is accepted.
//           otherwise hold.
//  - Latency: 1 cycle from accept to out_valid when the stage is EMPTY, or BUSY with release.
//  - Throughput: 1 entry/cycle when out_ready is held high. No bubble after FULL->BUSY.
//  - Ordering is strictly FIFO; no entry is duplicated or lost except by flush.
//  - stall_cnt and drop_cnt saturate at 2^CNT_W-1 and never wrap.
//  - out_valid = (state != EMPTY). Payload outputs hold their value while !release.
// STRUCTURE
//  - Shared package pipe_pkg holds:
//    - skid_state_t enum {EMPTY, BUSY, FULL}, 2 bits
//    - default width localparams DATA_W_DEF=64, RADDR_W_DEF=5, PPP_W_DEF=3
//    - packed struct wb_payload_t {wr_en, rd, rd_sel, alu, mem, ppp}
//  - Sub-module pipe_skid_ctrl: FSM and the load_R / load_S / R_from_S strobes only.
//    The top level holds the payload registers and counters.
// TESTING
//  1. Reset: reset high for 2 cycles with in_valid=1 -> out_valid=0, all outputs 0,
//     in_ready=1 after release, counters 0.
//  2. Streaming: out_ready=1, 8 back-to-back entries rd=1..8, alu=0x10*k ->
//     out_rd=1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
//  3. Backpressure: out_ready=0 while 3 entries are offered -> 2 accepted, state FULL,
//     in_ready=0, stall_cnt increments each cycle; out_ready=1 -> entries emerge in order,
//     third accepted once in_ready=1.
//  4. Flush when FULL: flush=1 with in_valid=1 -> next cycle out_valid=0, out_wr_en=0,
//     payload 0, drop_cnt=2; the input entry is not seen.
//  5. Reset mid-stream in BUSY, stall_cnt=5 -> next cycle EMPTY, stall_cnt=0, drop_cnt unchanged at 0.
//  6. Saturation: CNT_W=3, hold out_valid=1 & out_ready=0 for 10 cycles -> stall_cnt=7 and
//     stays 7; in_wr_en=1 on an entry never raises out_wr_en while out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the EX/MEM -> WB pipeline stage.
package pipe_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int RADDR_W_DEF = 5;
    localparam int PPP_W_DEF   = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic                   wr_en;
        logic [RADDR_W_DEF-1:0] rd;
        logic                   rd_sel;
        logic [DATA_W_DEF-1:0]  alu;
        logic [DATA_W_DEF-1:0]  mem;
        logic [PPP_W_DEF-1:0]   ppp;
    } wb_payload_t;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the 2-entry skid stage; emits payload load strobes only.
//   state | meaning
//   EMPTY | no entry held, out reg free
//   BUSY  | one entry in out reg
//   FULL  | out reg and skid reg both hold entries, upstream stalled
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        out_ready,
    output logic        in_ready,
    output logic        out_valid,
    output skid_state_t state,
    output logic        load_r,
    output logic        load_s,
    output logic        r_from_s
);

    skid_state_t state_nxt;
    logic        accept;
    logic        release_en;

    assign accept     = in_valid & in_ready;
    assign release_en = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        load_r    = 1'b0;
        load_s    = 1'b0;
        r_from_s  = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_r    = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && release_en) begin
                        load_r = 1'b1;
                    end else if (accept) begin
                        load_s    = 1'b1;
                        state_nxt = FULL;
                    end else if (release_en) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (release_en) begin
                        r_from_s  = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
        end
    end

endmodule

// File: rtl/exmem_wb_skid_stage.sv
// EX/MEM -> WB pipeline register with 2-entry skid buffer, flush and
// saturating stall/drop counters.
module exmem_wb_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int PPP_W   = PPP_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_wr_en,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_rd_sel,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_mem,
    input  logic [PPP_W-1:0]   in_ppp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_wr_en,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_rd_sel,
    output logic [DATA_W-1:0]  out_alu,
    output logic [DATA_W-1:0]  out_mem,
    output logic [PPP_W-1:0]   out_ppp,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    // Same field order as wb_payload_t, but sized by this instance's parameters.
    typedef struct packed {
        logic               wr_en;
        logic [RADDR_W-1:0] rd;
        logic               rd_sel;
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  mem;
        logic [PPP_W-1:0]   ppp;
    } payload_t;

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    payload_t    in_pl;
    payload_t    r_q;
    payload_t    s_q;
    skid_state_t state;
    logic        load_r;
    logic        load_s;
    logic        r_from_s;
    logic [1:0]  held;
    logic [CNT_W:0] drop_sum;

    assign in_pl = '{wr_en: in_wr_en, rd: in_rd, rd_sel: in_rd_sel,
                     alu: in_alu, mem: in_mem, ppp: in_ppp};

    pipe_skid_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .state     (state),
        .load_r    (load_r),
        .load_s    (load_s),
        .r_from_s  (r_from_s)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_q <= '0;
            s_q <= '0;
        end else begin
            if (load_r) begin
                r_q <= in_pl;
            end else if (r_from_s) begin
                r_q <= s_q;
            end
            if (load_s) begin
                s_q <= in_pl;
            end
        end
    end

    assign out_wr_en  = r_q.wr_en & out_valid;
    assign out_rd     = r_q.rd;
    assign out_rd_sel = r_q.rd_sel;
    assign out_alu    = r_q.alu;
    assign out_mem    = r_q.mem;
    assign out_ppp    = r_q.ppp;

    always_comb begin
        held = 2'd0;
        case (state)
            BUSY:    held = 2'd1;
            FULL:    held = 2'd2;
            default: held = 2'd0;
        endcase
    end

    // One spare bit catches the carry so the drop count clamps instead of wrapping.
    assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, held};

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && ({1'b0, stall_cnt} != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush) begin
                drop_cnt <= (drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_exmem_wb_skid_stage.sv
// Bench for exmem_wb_skid_stage: directed tables and sequences plus random
// traffic against a queue-based reference model; a CNT_W=3 copy checks saturation.
module tb_exmem_wb_skid_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_wr_en, in_rd_sel;
    logic [4:0]  in_rd;
    logic [63:0] in_alu, in_mem;
    logic [2:0]  in_ppp;

    logic        in_ready, out_valid, out_wr_en, out_rd_sel;
    logic [4:0]  out_rd;
    logic [63:0] out_alu, out_mem;
    logic [2:0]  out_ppp;
    logic [15:0] stall_cnt, drop_cnt;

    logic        b_in_ready, b_out_valid, b_out_wr_en, b_out_rd_sel;
    logic [4:0]  b_out_rd;
    logic [63:0] b_out_alu, b_out_mem;
    logic [2:0]  b_out_ppp;
    logic [2:0]  b_stall_cnt, b_drop_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exmem_wb_skid_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_wr_en(in_wr_en), .in_rd(in_rd), .in_rd_sel(in_rd_sel), .in_alu(in_alu),
        .in_mem(in_mem), .in_ppp(in_ppp), .out_valid(out_valid), .out_ready(out_ready),
        .out_wr_en(out_wr_en), .out_rd(out_rd), .out_rd_sel(out_rd_sel), .out_alu(out_alu),
        .out_mem(out_mem), .out_ppp(out_ppp), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    exmem_wb_skid_stage #(.CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_wr_en(in_wr_en), .in_rd(in_rd), .in_rd_sel(in_rd_sel), .in_alu(in_alu),
        .in_mem(in_mem), .in_ppp(in_ppp), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_wr_en(b_out_wr_en), .out_rd(b_out_rd), .out_rd_sel(b_out_rd_sel), .out_alu(b_out_alu),
        .out_mem(b_out_mem), .out_ppp(b_out_ppp), .stall_cnt(b_stall_cnt), .drop_cnt(b_drop_cnt)
    );

    // Reference model: a FIFO of held entries plus the last value shown on the output.
    wb_payload_t q[$];
    wb_payload_t last_out = '0;
    bit          m_rdy = 1'b1;
    int          m_stall = 0;
    int          m_drop = 0;

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        wb_payload_t cur;
        bit acc, rel;
        cur = '{wr_en: in_wr_en, rd: in_rd, rd_sel: in_rd_sel, alu: in_alu, mem: in_mem, ppp: in_ppp};
        if (reset) begin
            q.delete();
            last_out = '0;
            m_rdy    = 1'b1;
            m_stall  = 0;
            m_drop   = 0;
        end else begin
            acc = in_valid && m_rdy;
            rel = (q.size() > 0) && out_ready;
            if (q.size() > 0 && !out_ready) m_stall++;
            if (flush) begin
                m_drop  += q.size();
                q.delete();
                last_out = '0;
            end else begin
                if (rel) last_out = q.pop_front();
                if (acc) q.push_back(cur);
            end
            m_rdy = (q.size() < 2);
        end
    endtask

    task automatic check_model();
        wb_payload_t h;
        bit v;
        v = (q.size() > 0);
        h = v ? q[0] : last_out;
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("in_ready",  64'(in_ready),  64'(m_rdy));
        chk("out_wr_en", 64'(out_wr_en), 64'(v && h.wr_en));
        chk("out_rd",    64'(out_rd),    64'(h.rd));
        chk("out_rd_sel",64'(out_rd_sel),64'(h.rd_sel));
        chk("out_alu",   out_alu,        h.alu);
        chk("out_mem",   out_mem,        h.mem);
        chk("out_ppp",   64'(out_ppp),   64'(h.ppp));
        chk("stall_cnt", 64'(stall_cnt), 64'(clamp(m_stall, 65535)));
        chk("drop_cnt",  64'(drop_cnt),  64'(clamp(m_drop, 65535)));
        chk("b_stall_cnt", 64'(b_stall_cnt), 64'(clamp(m_stall, 7)));
        chk("b_drop_cnt",  64'(b_drop_cnt),  64'(clamp(m_drop, 7)));
        chk("b_out_rd",    64'(b_out_rd),    64'(h.rd));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input bit iv, input bit ordy, input logic [4:0] rd, input bit wr);
        in_valid  = iv;
        out_ready = ordy;
        in_rd     = rd;
        in_wr_en  = wr;
        in_alu    = 64'h10 * rd;
        in_mem    = {32'hC0DE, 27'd0, rd};
        in_ppp    = rd[2:0];
        in_rd_sel = rd[0];
    endtask

    typedef struct {
        bit         iv;
        bit         ordy;
        logic [4:0] rd;
        bit         e_valid;
        bit         e_ready;
        logic [4:0] e_rd;
        int         e_stall;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Streaming rows, then backpressure rows (out reg = first held, skid = second).
        for (int k = 1; k <= 8; k++) tbl[k-1] = '{1, 1, 5'(k), 1, 1, 5'(k), 0};
        tbl[8]  = '{0, 1, 5'd0,  0, 1, 5'd8,  0};
        tbl[9]  = '{1, 0, 5'd9,  1, 1, 5'd9,  0};
        tbl[10] = '{1, 0, 5'd10, 1, 0, 5'd9,  1};
        tbl[11] = '{1, 0, 5'd11, 1, 0, 5'd9,  2};
        tbl[12] = '{1, 1, 5'd11, 1, 1, 5'd10, 2};
        tbl[13] = '{1, 1, 5'd11, 1, 1, 5'd11, 2};
        tbl[14] = '{0, 1, 5'd0,  0, 1, 5'd11, 2};

        reset = 1'b1;
        flush = 1'b0;
        drive(1, 0, 5'd3, 1);
        cyc();
        cyc();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_wr_en", 64'(out_wr_en), 64'd0);
        chk("rst_alu", out_alu, 64'd0);
        reset = 1'b0;
        drive(0, 0, 5'd0, 0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_stall", 64'(stall_cnt), 64'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].rd, 1'b1);
            cyc();
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_rd", i), 64'(out_rd), 64'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_alu", i), out_alu, 64'h10 * tbl[i].e_rd);
            chk($sformatf("tbl%0d_wr", i), 64'(out_wr_en), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_stall", i), 64'(stall_cnt), 64'(tbl[i].e_stall));
        end

        // Flush while FULL, with a concurrent offer that must be discarded.
        drive(1, 0, 5'd20, 1);
        cyc();
        drive(1, 0, 5'd21, 1);
        cyc();
        chk("full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1, 0, 5'd22, 1);
        cyc();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_wr_en", 64'(out_wr_en), 64'd0);
        chk("flush_rd", 64'(out_rd), 64'd0);
        chk("flush_alu", out_alu, 64'd0);
        chk("flush_drop", 64'(drop_cnt), 64'd2);
        drive(0, 1, 5'd0, 0);
        cyc();
        chk("flush_no_ghost", 64'(out_valid), 64'd0);

        // Reset in BUSY after five stalled cycles.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(1, 0, 5'd5, 1);
        cyc();
        drive(0, 0, 5'd0, 0);
        repeat (5) cyc();
        chk("busy_stall5", 64'(stall_cnt), 64'd5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_stall", 64'(stall_cnt), 64'd0);
        chk("rst2_drop", 64'(drop_cnt), 64'd0);

        // Saturation of the 3-bit copy, and wr_en gating while invalid.
        drive(1, 0, 5'd7, 1);
        cyc();
        drive(0, 0, 5'd0, 1);
        repeat (10) cyc();
        chk("sat_b_stall", 64'(b_stall_cnt), 64'd7);
        chk("sat_stall", 64'(stall_cnt), 64'd10);
        drive(0, 1, 5'd0, 1);
        cyc();
        chk("idle_wr_en", 64'(out_wr_en), 64'd0);
        chk("idle_hold_rd", 64'(out_rd), 64'd7);
        drive(0, 0, 5'd0, 1);
        cyc();
        chk("sat_b_hold", 64'(b_stall_cnt), 64'd7);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_wr_en  = 1'($urandom);
            in_rd     = 5'($urandom);
            in_rd_sel = 1'($urandom);
            in_alu    = {$urandom, $urandom};
            in_mem    = {$urandom, $urandom};
            in_ppp    = 3'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
